// File: rtl/sr_pulse_sequencer.sv
// Drives the S/R inputs of an external SR latch: arbitrates set/reset requests,
// issues one fixed-width pulse per grant, then checks Q feedback against the expected state.
module sr_pulse_sequencer #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic rst_req,
    input  logic clr_err,
    input  logic Q_fb,
    output logic S,
    output logic R,
    output logic set_ack,
    output logic rst_ack,
    output logic busy,
    output logic state_q,
    output logic mismatch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } fsm_e;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LD   = (GAP_W == 0) ? 4'd0 : 4'(GAP_W - 1);

    fsm_e       fsm_q, fsm_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_op_q, last_op_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       sack_q, sack_d;
    logic       rack_q, rack_d;
    logic       exp_q, exp_d;
    logic       mis_q, mis_d;
    logic       arb_any;
    logic       arb_set;
    logic       grant;

    // With both requests pending, alternate away from the last operation.
    assign arb_any = set_req | rst_req;
    assign arb_set = set_req & (~rst_req | ~last_op_q);

    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        last_op_d = last_op_q;
        s_d       = 1'b0;
        r_d       = 1'b0;
        sack_d    = 1'b0;
        rack_d    = 1'b0;
        exp_d     = exp_q;
        mis_d     = mis_q;
        grant     = 1'b0;

        case (fsm_q)
            IDLE: begin
                grant = arb_any;
            end
            PULSE: begin
                if (cnt_q == 4'd0) begin
                    if (GAP_W == 0) begin
                        fsm_d = CHECK;
                    end else begin
                        fsm_d = GAP;
                        cnt_d = GAP_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    s_d   = s_q;
                    r_d   = r_q;
                end
            end
            GAP: begin
                if (cnt_q == 4'd0) begin
                    fsm_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                // The edge ending CHECK is also an arbitration point, giving
                // back-to-back grants a spacing of PULSE_W+GAP_W+1 cycles.
                fsm_d = IDLE;
                grant = arb_any;
            end
            default: fsm_d = IDLE;
        endcase

        if (grant) begin
            fsm_d     = PULSE;
            cnt_d     = PULSE_LD;
            s_d       = arb_set;
            r_d       = ~arb_set;
            sack_d    = arb_set;
            rack_d    = ~arb_set;
            exp_d     = arb_set;
            last_op_d = arb_set;
        end

        // A failing check outranks a simultaneous clear.
        if (fsm_q == CHECK && Q_fb != exp_q) begin
            mis_d = 1'b1;
        end else if (clr_err) begin
            mis_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= IDLE;
            cnt_q     <= 4'd0;
            last_op_q <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            sack_q    <= 1'b0;
            rack_q    <= 1'b0;
            exp_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            last_op_q <= last_op_d;
            s_q       <= s_d;
            r_q       <= r_d;
            sack_q    <= sack_d;
            rack_q    <= rack_d;
            exp_q     <= exp_d;
            mis_q     <= mis_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign set_ack  = sack_q;
    assign rst_ack  = rack_q;
    assign busy     = (fsm_q != IDLE);
    assign state_q  = exp_q;
    assign mismatch = mis_q;

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// Directed bench for sr_pulse_sequencer at PULSE_W=2, GAP_W=1; expected values hand-derived.
module tb_sr_pulse_sequencer;

    logic clk = 1'b0;
    logic rst, set_req, rst_req, clr_err, Q_fb;
    logic S, R, set_ack, rst_ack, busy, state_q, mismatch;
    int n_cmp = 0;
    int n_err = 0;

    sr_pulse_sequencer #(.PULSE_W(2), .GAP_W(1)) dut (
        .clk(clk), .rst(rst), .set_req(set_req), .rst_req(rst_req),
        .clr_err(clr_err), .Q_fb(Q_fb), .S(S), .R(R),
        .set_ack(set_ack), .rst_ack(rst_ack), .busy(busy),
        .state_q(state_q), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge, settle, and confirm S and R are never high together.
    task automatic step();
        @(posedge clk);
        #1;
        chk("s_and_r_excl", S & R, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; set_req = 1'b0; rst_req = 1'b0; clr_err = 1'b0; Q_fb = 1'b0;
        do_reset();
        chk("rst_S", S, 1'b0);
        chk("rst_R", R, 1'b0);
        chk("rst_set_ack", set_ack, 1'b0);
        chk("rst_rst_ack", rst_ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state_q", state_q, 1'b0);
        chk("rst_mismatch", mismatch, 1'b0);

        // Single set with good feedback
        set_req = 1'b1; Q_fb = 1'b1;
        step();                                     // cycle 1
        set_req = 1'b0;
        chk("s1_c1_set_ack", set_ack, 1'b1);
        chk("s1_c1_S", S, 1'b1);
        chk("s1_c1_busy", busy, 1'b1);
        chk("s1_c1_state_q", state_q, 1'b1);
        step();                                     // cycle 2
        chk("s1_c2_set_ack", set_ack, 1'b0);
        chk("s1_c2_S", S, 1'b1);
        step();                                     // cycle 3
        chk("s1_c3_S", S, 1'b0);
        chk("s1_c3_busy", busy, 1'b1);
        step();                                     // cycle 4 (CHECK)
        chk("s1_c4_busy", busy, 1'b1);
        chk("s1_c4_S", S, 1'b0);
        step();                                     // cycle 5
        chk("s1_c5_busy", busy, 1'b0);
        chk("s1_c5_mismatch", mismatch, 1'b0);
        chk("s1_c5_state_q", state_q, 1'b1);

        // Simultaneous requests after reset: set first, then reset
        do_reset();
        set_req = 1'b1; rst_req = 1'b1; Q_fb = 1'b1;
        step();                                     // cycle 1
        set_req = 1'b0;
        chk("sim_c1_set_ack", set_ack, 1'b1);
        chk("sim_c1_rst_ack", rst_ack, 1'b0);
        chk("sim_c1_S", S, 1'b1);
        chk("sim_c1_R", R, 1'b0);
        step();                                     // cycle 2
        step();                                     // cycle 3
        step();                                     // cycle 4
        chk("sim_c4_rst_ack", rst_ack, 1'b0);
        chk("sim_c4_R", R, 1'b0);
        step();                                     // cycle 5
        rst_req = 1'b0; Q_fb = 1'b0;
        chk("sim_c5_rst_ack", rst_ack, 1'b1);
        chk("sim_c5_R", R, 1'b1);
        chk("sim_c5_state_q", state_q, 1'b0);
        step();                                     // cycle 6
        chk("sim_c6_R", R, 1'b1);
        chk("sim_c6_rst_ack", rst_ack, 1'b0);
        step();                                     // cycle 7
        chk("sim_c7_R", R, 1'b0);
        step();                                     // cycle 8
        step();                                     // cycle 9
        chk("sim_c9_busy", busy, 1'b0);
        chk("sim_c9_state_q", state_q, 1'b0);
        chk("sim_c9_mismatch", mismatch, 1'b0);

        // Stuck feedback, then clear
        set_req = 1'b1; Q_fb = 1'b0;
        step();
        set_req = 1'b0;
        step(); step(); step();                     // cycles 2..4
        chk("stk_c4_mismatch", mismatch, 1'b0);
        step();                                     // cycle 5
        chk("stk_c5_mismatch", mismatch, 1'b1);
        step(); step();
        chk("stk_idle_mismatch", mismatch, 1'b1);
        chk("stk_idle_busy", busy, 1'b0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("stk_clr_mismatch", mismatch, 1'b0);

        // Clear colliding with a failing check
        set_req = 1'b1; Q_fb = 1'b0;
        step();
        set_req = 1'b0;
        step(); step(); step();                     // cycle 4 (CHECK)
        clr_err = 1'b1;
        step();                                     // cycle 5
        clr_err = 1'b0;
        chk("col_mismatch", mismatch, 1'b1);

        // Reset in cycle 1 of a set (mismatch is still 1 going in)
        set_req = 1'b1; Q_fb = 1'b0;
        step();                                     // cycle 1
        set_req = 1'b0;
        chk("rmp_c1_S", S, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmp_S", S, 1'b0);
        chk("rmp_busy", busy, 1'b0);
        chk("rmp_state_q", state_q, 1'b0);
        chk("rmp_mismatch", mismatch, 1'b0);
        chk("rmp_set_ack", set_ack, 1'b0);
        Q_fb = 1'b1;
        step(); step(); step(); step(); step();
        chk("rmp_nocheck_mismatch", mismatch, 1'b0);
        chk("rmp_nocheck_busy", busy, 1'b0);

        // One-cycle reset request during a busy set is lost
        set_req = 1'b1; Q_fb = 1'b1;
        step();                                     // cycle 1
        set_req = 1'b0;
        step();                                     // cycle 2
        rst_req = 1'b1;
        step();                                     // cycle 3
        rst_req = 1'b0;
        chk("rdb_c3_rst_ack", rst_ack, 1'b0);
        chk("rdb_c3_R", R, 1'b0);
        step();                                     // cycle 4
        chk("rdb_c4_rst_ack", rst_ack, 1'b0);
        step();                                     // cycle 5
        chk("rdb_c5_busy", busy, 1'b0);
        chk("rdb_c5_rst_ack", rst_ack, 1'b0);
        step();
        chk("rdb_c6_R", R, 1'b0);
        chk("rdb_c6_mismatch", mismatch, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sr_pulse_sequencer.md
# sr_pulse_sequencer

Controller that owns the S and R inputs of one external SR latch. It arbitrates set and reset requests from its clients and issues one clean, fixed-width S or R pulse per grant. It inserts a guard gap so S and R are never high together. After each operation it checks the latch's Q feedback against the expected state and records any disagreement in a sticky error flag.

## Interface
- PULSE_W, 2, width of the S/R pulse in clk cycles; legal 1..15
- GAP_W, 1, cycles with S=R=0 after each pulse, before the check; legal 0..15
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- set_req  input  1  level request to set the latch; held until set_ack
- rst_req  input  1  level request to reset the latch; held until rst_ack
- clr_err  input  1  clears the mismatch flag
- Q_fb  input  1  Q output of the driven latch, assumed stable in the CHECK state
- S  output  1  registered set drive to the latch
- R  output  1  registered reset drive to the latch
- set_ack  output  1  one-cycle grant pulse for set_req
- rst_ack  output  1  one-cycle grant pulse for rst_req
- busy  output  1  high whenever the FSM is not in IDLE
- state_q  output  1  expected latch state, updated at grant
- mismatch  output  1  sticky: Q_fb differed from state_q in a CHECK cycle

## Operation
- The FSM has four states: IDLE, PULSE, GAP, CHECK. An internal down-counter is 4 bits wide. last_op is 1 bit (0 = reset, 1 = set).
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the operation opposite to last_op.
  - If neither is high, stay in IDLE.
- Grant (taken on the clock edge where IDLE samples the request):
  - Next state is PULSE; the counter loads PULSE_W-1.
  - For a set, drive S=1; for a reset, drive R=1.
  - Pulse the matching ack for one cycle.
  - state_q <= 1 for a set, 0 for a reset.
  - last_op <= the granted operation.
- PULSE:
  - Hold the active drive high.
  - When the counter reaches 0, drop S and R. Go to GAP with the counter loaded to GAP_W-1, or go straight to CHECK if GAP_W=0.
- GAP: S=R=0. When the counter reaches 0, go to CHECK.
- CHECK: a single cycle. If Q_fb != state_q, set mismatch. Then return to IDLE.
- Requests:
  - Requests are sampled only in IDLE.
  - The requester must deassert its request in the cycle after it sees its ack. A request still high in IDLE is treated as a new request.
  - A request pulse that falls entirely within a busy period is lost.
- Redundant operations (a set while state_q=1) are still pulsed and checked.
- mismatch is cleared on the edge where clr_err=1. If a CHECK detection happens in the same cycle, the detection wins and mismatch stays 1.
- Invariant: S&R is never 1 in any cycle, including across reset and back-to-back grants.

## Timing
- Reset values: S=0, R=0, set_ack=0, rst_ack=0, busy=0, state_q=0, mismatch=0. Internally, state=IDLE, last_op=0 (reset), counter=0.
- Reset taken mid-operation: all outputs return to their reset values on the next edge. The pending operation is abandoned and is not checked.
- Latency: a request sampled at edge k gives the ack and S (or R) high in cycle k+1.
- Drive length: S or R is high for exactly PULSE_W cycles.
- busy: high for PULSE_W+GAP_W+1 cycles, from k+1 through the CHECK cycle.
- Back-to-back throughput: the next grant happens no earlier than the edge ending the CHECK cycle. The minimum spacing between consecutive grants is PULSE_W+GAP_W+1 cycles.
- Separation between opposite drives: the falling edge of S and the rising edge of R are at least GAP_W+1 cycles apart (the GAP cycles plus CHECK).

## Test plan
All scenarios use PULSE_W=2, GAP_W=1, with the grant edge called cycle 0.
- Single set: set_req=1 for one cycle after reset, Q_fb=1 -> set_ack=1 in cycle 1; S=1 in cycles 1–2; S=0 in cycle 3; CHECK in cycle 4; busy=1 in cycles 1–4; state_q=1; mismatch=0; IDLE in cycle 5.
- Simultaneous requests: set_req and rst_req both raised after reset and each held until its ack -> set is granted first (last_op=reset). rst_ack then arrives in cycle 5 with R=1 in cycles 5–6. S&R=0 in every cycle; state_q ends at 0.
- Stuck feedback: a set with Q_fb held at 0 -> mismatch=1 after cycle 4 and stays set through later IDLE cycles. clr_err=1 clears it on the next edge.
- Clear/detect collision: clr_err=1 in the same cycle as a failing CHECK -> mismatch=1.
- Reset mid-pulse: rst=1 in cycle 1 of a set -> S=0, busy=0, state_q=0, mismatch=0 after the edge. No check occurs.
- Request during busy: a one-cycle rst_req in cycle 2 of a set -> no rst_ack and no R pulse. FSM is in IDLE in cycle 5.
